// File: rtl/alu_pipe.sv
// alu_pipe
// --------
// Pipelined ALU with a valid/ready handshake on both sides. Each accepted
// operation is evaluated combinationally from the input operands and the
// result, flags and error bit are captured into stage 0. Stages 1..STAGES-1
// are pure delay. The last stage drives the outputs directly. One global
// stall freezes every stage whenever a valid result is waiting on
// downstream.
//
// Parameters
//   WIDTH   operand/result width in bits (>= 2)
//   STAGES  pipeline register stages from acceptance to output (>= 1)
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   op_in      4-bit opcode
//   a_in       operand A
//   b_in       operand B, also the unsigned shift amount for shifts
//   in_valid   upstream offers an operation
//   in_ready   block can accept an operation this cycle
//   out        result
//   flags_out  {overflow, carry, negative, zero}
//   err_out    result came from an undefined opcode
//   out_valid  out/flags_out/err_out are valid
//   out_ready  downstream accepts the result this cycle

module alu_pipe #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       op_in,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out,
   output logic [3:0]       flags_out,
   output logic             err_out,
   output logic             out_valid,
   input  logic             out_ready
);

   typedef enum logic [3:0] {
      OP_AND   = 4'd0,
      OP_NAND  = 4'd1,
      OP_OR    = 4'd2,
      OP_NOR   = 4'd3,
      OP_XOR   = 4'd4,
      OP_XNOR  = 4'd5,
      OP_NOTA  = 4'd6,
      OP_NOTB  = 4'd7,
      OP_ADD   = 4'd8,
      OP_SUB   = 4'd9,
      OP_SHL   = 4'd10,
      OP_SHR   = 4'd11,
      OP_SRA   = 4'd12
   } opcode_t;

   // WIDTH always fits in WIDTH bits for WIDTH >= 2, so the shift amount can
   // be compared against it without widening b_in.
   localparam logic [WIDTH-1:0] SHIFT_LIMIT = WIDTH'(WIDTH);

   logic              stall;

   logic [STAGES-1:0] stageValid;
   logic [WIDTH-1:0]  stageResult [STAGES];
   logic [3:0]        stageFlags  [STAGES];
   logic              stageErr    [STAGES];

   logic [WIDTH:0]    addSum;
   logic [WIDTH:0]    subSum;
   logic [WIDTH:0]    shlExt;
   logic [WIDTH:0]    shrExt;
   logic [WIDTH:0]    sraExt;
   logic              bigShift;
   logic              signA;

   logic [WIDTH-1:0]  aluResult;
   logic              aluCarry;
   logic              aluOverflow;
   logic              aluErr;
   logic [3:0]        aluFlags;

   // A valid result sitting at the output that downstream refuses freezes
   // the whole pipeline. While reset is held nothing may be accepted.
   assign stall    = out_valid & ~out_ready;
   assign in_ready = rst_n & ~stall;

   // Arithmetic uses one extra bit so the carry falls out as the top bit.
   // Subtraction is a + ~b + 1, so a set top bit means no borrow occurred.
   assign addSum = {1'b0, a_in} + {1'b0, b_in};
   assign subSum = {1'b0, a_in} + {1'b0, ~b_in} + (WIDTH+1)'(1);

   // Shifts are done on a vector one bit wider than the operand so the last
   // bit shifted out lands in the extra position: the top bit for a left
   // shift and the bottom bit for right shifts. A zero shift leaves the
   // extra bit at zero, which is exactly the required carry for that case.
   assign shlExt   = {1'b0, a_in} << b_in;
   assign shrExt   = {a_in, 1'b0} >> b_in;
   assign sraExt   = $unsigned($signed({a_in, 1'b0}) >>> b_in);
   assign bigShift = (b_in >= SHIFT_LIMIT);
   assign signA    = a_in[WIDTH-1];

   // Operation decode. Logic and NOT ops never set carry or overflow,
   // shifts never set overflow, and undefined opcodes return an all-zero
   // result with the error bit set.
   always_comb begin
      aluResult   = '0;
      aluCarry    = 1'b0;
      aluOverflow = 1'b0;
      aluErr      = 1'b0;
      case (op_in)
         OP_AND:  aluResult = a_in & b_in;
         OP_NAND: aluResult = ~(a_in & b_in);
         OP_OR:   aluResult = a_in | b_in;
         OP_NOR:  aluResult = ~(a_in | b_in);
         OP_XOR:  aluResult = a_in ^ b_in;
         OP_XNOR: aluResult = ~(a_in ^ b_in);
         OP_NOTA: aluResult = ~a_in;
         OP_NOTB: aluResult = ~b_in;
         OP_ADD: begin
            aluResult   = addSum[WIDTH-1:0];
            aluCarry    = addSum[WIDTH];
            aluOverflow = (signA == b_in[WIDTH-1]) &&
                          (addSum[WIDTH-1] != signA);
         end
         OP_SUB: begin
            aluResult   = subSum[WIDTH-1:0];
            aluCarry    = subSum[WIDTH];
            aluOverflow = (signA != b_in[WIDTH-1]) &&
                          (subSum[WIDTH-1] != signA);
         end
         OP_SHL: begin
            if (bigShift) begin
               aluResult = '0;
               aluCarry  = 1'b0;
            end else begin
               aluResult = shlExt[WIDTH-1:0];
               aluCarry  = shlExt[WIDTH];
            end
         end
         OP_SHR: begin
            if (bigShift) begin
               aluResult = '0;
               aluCarry  = 1'b0;
            end else begin
               aluResult = shrExt[WIDTH:1];
               aluCarry  = shrExt[0];
            end
         end
         OP_SRA: begin
            if (bigShift) begin
               aluResult = {WIDTH{signA}};
               aluCarry  = signA;
            end else begin
               aluResult = sraExt[WIDTH:1];
               aluCarry  = sraExt[0];
            end
         end
         default: begin
            aluResult = '0;
            aluErr    = 1'b1;
         end
      endcase
   end

   // Flags are assembled once the result is known. An undefined opcode
   // reports all flags clear even though its zero result would otherwise
   // raise the zero flag.
   always_comb begin
      aluFlags = 4'b0000;
      if (!aluErr) begin
         aluFlags = {aluOverflow, aluCarry, aluResult[WIDTH-1],
                     (aluResult == '0)};
      end
   end

   // Pipeline registers. All stages advance together when not stalled and
   // hold together when stalled. Valid bits always shift so bubbles travel
   // with the data, but payload only loads alongside a valid entry so the
   // outputs keep their last meaningful values while a bubble passes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stageValid <= '0;
         for (int i = 0; i < STAGES; i++) begin
            stageResult[i] <= '0;
            stageFlags[i]  <= '0;
            stageErr[i]    <= 1'b0;
         end
      end else if (!stall) begin
         stageValid[0] <= in_valid;
         if (in_valid) begin
            stageResult[0] <= aluResult;
            stageFlags[0]  <= aluFlags;
            stageErr[0]    <= aluErr;
         end
         for (int i = 1; i < STAGES; i++) begin
            stageValid[i] <= stageValid[i-1];
            if (stageValid[i-1]) begin
               stageResult[i] <= stageResult[i-1];
               stageFlags[i]  <= stageFlags[i-1];
               stageErr[i]    <= stageErr[i-1];
            end
         end
      end
   end

   // The last stage is the output register.
   assign out_valid = stageValid[STAGES-1];
   assign out       = stageResult[STAGES-1];
   assign flags_out = stageFlags[STAGES-1];
   assign err_out   = stageErr[STAGES-1];

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe
// -----------
// Bench for alu_pipe at WIDTH=8, STAGES=2. Directed operations are issued
// by a driver that pushes the hand-computed expected response into a
// queue at the moment of acceptance; an independent monitor compares the
// head of that queue with whatever the DUT presents while out_valid is high
// and pops it when downstream accepts.

module tb_alu_pipe;

   localparam int WIDTH  = 8;
   localparam int STAGES = 2;

   logic             clk;
   logic             rst_n;
   logic [3:0]       op_in;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] out;
   logic [3:0]       flags_out;
   logic             err_out;
   logic             out_valid;
   logic             out_ready;

   typedef struct {
      logic [WIDTH-1:0] res;
      logic [3:0]       flags;
      logic             err;
      int               acceptCyc;
      bit               checkLat;
   } expect_t;

   expect_t sbQueue[$];
   bit      seenFront;
   bit      latencyCheckOn;
   int      cyc;
   int      total;
   int      bad;

   alu_pipe #(
      .WIDTH  (WIDTH),
      .STAGES (STAGES)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .op_in     (op_in),
      .a_in      (a_in),
      .b_in      (b_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out       (out),
      .flags_out (flags_out),
      .err_out   (err_out),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cycle counter used to measure acceptance-to-output latency.
   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Hard stop in case something upstream of the bounded waits wedges.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired at cyc=%0d", cyc);
      $fatal(1, "[TB] watchdog");
   end

   // Single comparison point: every check goes through here so the
   // counters printed at the end are the ones stepped by the checks.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cyc=%0d)",
                  name, actual, expected, cyc);
      end
   endtask

   // Offer one operation and hold it until accepted. Acceptance is decided
   // at the negedge before the accepting rising edge, which is when the
   // expected response is queued. Returns just after the accepting edge so
   // a following call continues back-to-back.
   task automatic applyStimulus(input logic [3:0] op, input logic [7:0] a,
                                input logic [7:0] b, input logic [7:0] expOut,
                                input logic [3:0] expFlags,
                                input logic expErr);
      expect_t e;
      int      waitCount;
      op_in     = op;
      a_in      = a;
      b_in      = b;
      in_valid  = 1'b1;
      waitCount = 0;
      forever begin
         @(negedge clk);
         if (in_ready) begin
            e.res       = expOut;
            e.flags     = expFlags;
            e.err       = expErr;
            e.acceptCyc = cyc;
            e.checkLat  = latencyCheckOn;
            sbQueue.push_back(e);
            @(posedge clk);
            #1;
            break;
         end
         waitCount++;
         if (waitCount >= 20) begin
            checkOutput("accept_timeout", 32'(in_ready), 32'd1);
            @(posedge clk);
            #1;
            break;
         end
      end
   endtask

   // Drop in_valid and let the clock run.
   task automatic idleCycles(input int n);
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Wait for every queued response to come out, bounded.
   task automatic drainQueue();
      int n;
      n = 0;
      while (sbQueue.size() != 0 && n < 60) begin
         @(posedge clk);
         n++;
      end
      #1;
      checkOutput("drain_left", 32'(sbQueue.size()), 32'd0);
   endtask

   // Monitor: on each negedge with a valid output, compare against the head
   // of the queue. The same head is compared on every stalled cycle so a
   // result that changes under backpressure is caught. Latency is checked
   // the first time a given head is seen.
   initial begin
      expect_t front;
      seenFront = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n && out_valid) begin
            if (sbQueue.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL unexpected_output: got out=0x%0h flags=0x%0h err=%0b expected none (cyc=%0d)",
                        out, flags_out, err_out, cyc);
            end else begin
               front = sbQueue[0];
               if (!seenFront) begin
                  seenFront = 1'b1;
                  if (front.checkLat) begin
                     checkOutput("latency", 32'(cyc - front.acceptCyc),
                                 32'(STAGES));
                  end
               end
               checkOutput("out", 32'(out), 32'(front.res));
               checkOutput("flags", 32'(flags_out), 32'(front.flags));
               checkOutput("err", 32'(err_out), 32'(front.err));
               if (out_ready) begin
                  void'(sbQueue.pop_front());
                  seenFront = 1'b0;
               end
            end
         end
      end
   end

   // Directed sequence.
   initial begin
      op_in          = 4'd0;
      a_in           = '0;
      b_in           = '0;
      in_valid       = 1'b0;
      out_ready      = 1'b1;
      latencyCheckOn = 1'b0;
      total          = 0;
      bad            = 0;
      rst_n          = 1'b1;
      #2 rst_n       = 1'b0;

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
      checkOutput("rst_out", 32'(out), 32'd0);
      checkOutput("rst_flags", 32'(flags_out), 32'd0);
      checkOutput("rst_err", 32'(err_out), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);

      // Back-to-back operations with downstream always ready.
      $display("[TB] directed ops, out_ready held high");
      latencyCheckOn = 1'b1;
      applyStimulus(4'd8,  8'h7F, 8'h01, 8'h80, 4'b1010, 1'b0);
      applyStimulus(4'd9,  8'h05, 8'h05, 8'h00, 4'b0101, 1'b0);
      applyStimulus(4'd9,  8'h00, 8'h01, 8'hFF, 4'b0010, 1'b0);
      applyStimulus(4'd12, 8'h90, 8'h09, 8'hFF, 4'b0110, 1'b0);
      applyStimulus(4'd10, 8'h81, 8'h01, 8'h02, 4'b0100, 1'b0);
      applyStimulus(4'd14, 8'h12, 8'h34, 8'h00, 4'b0000, 1'b1);
      applyStimulus(4'd1,  8'hF0, 8'h3C, 8'hCF, 4'b0010, 1'b0);
      applyStimulus(4'd8,  8'hFF, 8'h01, 8'h00, 4'b0101, 1'b0);
      applyStimulus(4'd9,  8'h80, 8'h01, 8'h7F, 4'b1100, 1'b0);
      applyStimulus(4'd11, 8'h80, 8'h08, 8'h00, 4'b0001, 1'b0);
      applyStimulus(4'd7,  8'h00, 8'h0F, 8'hF0, 4'b0010, 1'b0);
      applyStimulus(4'd10, 8'h81, 8'h00, 8'h81, 4'b0010, 1'b0);
      applyStimulus(4'd5,  8'h0F, 8'h0F, 8'hFF, 4'b0010, 1'b0);
      applyStimulus(4'd3,  8'h00, 8'h00, 8'hFF, 4'b0010, 1'b0);
      applyStimulus(4'd12, 8'h40, 8'h03, 8'h08, 4'b0000, 1'b0);
      applyStimulus(4'd15, 8'hAA, 8'h55, 8'h00, 4'b0000, 1'b1);
      applyStimulus(4'd6,  8'h0F, 8'h00, 8'hF0, 4'b0010, 1'b0);
      idleCycles(1);
      applyStimulus(4'd11, 8'h03, 8'h01, 8'h01, 4'b0100, 1'b0);
      idleCycles(2);
      drainQueue();

      // Four ops with downstream refusing for three cycles as soon as the
      // first result appears.
      $display("[TB] backpressure stream");
      latencyCheckOn = 1'b0;
      fork
         begin
            applyStimulus(4'd0,  8'hF0, 8'h3C, 8'h30, 4'b0000, 1'b0);
            applyStimulus(4'd2,  8'h0F, 8'hF0, 8'hFF, 4'b0010, 1'b0);
            applyStimulus(4'd4,  8'hAA, 8'hAA, 8'h00, 4'b0001, 1'b0);
            applyStimulus(4'd11, 8'h81, 8'h01, 8'h40, 4'b0100, 1'b0);
            idleCycles(1);
         end
         begin
            int waitCount;
            waitCount = 0;
            while (!out_valid && waitCount < 20) begin
               @(posedge clk);
               #1;
               waitCount++;
            end
            checkOutput("stream_first_valid", 32'(out_valid), 32'd1);
            out_ready = 1'b0;
            repeat (3) begin
               @(negedge clk);
               checkOutput("in_ready_stalled", 32'(in_ready), 32'd0);
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drainQueue();

      // Reset while two ops are in flight and the output is stalled.
      $display("[TB] reset during stall");
      out_ready = 1'b0;
      applyStimulus(4'd8, 8'h10, 8'h20, 8'h30, 4'b0000, 1'b0);
      applyStimulus(4'd8, 8'h11, 8'h22, 8'h33, 4'b0000, 1'b0);
      idleCycles(2);
      checkOutput("inflight_valid", 32'(out_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd0);
      sbQueue.delete();
      seenFront = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      checkOutput("no_stale_output", 32'(out_valid), 32'd0);
      latencyCheckOn = 1'b1;
      applyStimulus(4'd8, 8'h01, 8'h02, 8'h03, 4'b0000, 1'b0);
      idleCycles(1);
      drainQueue();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
